// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART transmit path.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Code 11 is reserved and behaves as no parity.
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous show-ahead FIFO; pointers carry one extra bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     CLK,
  input  logic                     i_reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_dat,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE  = 1;
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign level  = wr_ptr - rd_ptr;
  assign full   = (level == FULL_LVL);
  assign empty  = (wr_ptr == rd_ptr);
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  // Storage is deliberately left unreset; only the pointers define contents.
  always_ff @(posedge CLK) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end

  always_ff @(posedge CLK or posedge i_reset) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO; frame settings are captured per word at pop time.
//   state     | meaning
//   ST_IDLE   | line high, waiting for enable and a queued word
//   ST_START  | start bit (0)
//   ST_DATA   | data bits, LSB first
//   ST_PARITY | parity bit, only when parity is selected
//   ST_STOP   | one or two stop bits (1), may chain straight into ST_START
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          CLK,
  input  logic                          i_reset,
  input  logic [DIV_W-1:0]              i_cycles_per_bit,
  input  logic [1:0]                    i_parity_mode,
  input  logic                          i_two_stop,
  input  logic                          i_enable,
  input  logic                          i_write,
  input  logic [DATA_BITS-1:0]          i_dat,
  output logic                          o_ready,
  output logic                          o_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_busy,
  output logic                          o_sout
);

  localparam int BC_W = 4;

  uart_state_e          state_q, state_d;
  logic [BC_W-1:0]      bit_q, bit_d;
  logic [DIV_W-1:0]     timer_q;
  logic [DIV_W-1:0]     cpb_q;
  logic [1:0]           par_q;
  logic                 two_q;
  logic                 par_bit_q;
  logic [DATA_BITS-1:0] data_q;
  logic [DATA_BITS-1:0] fifo_dat;
  logic                 fifo_full, fifo_empty;
  logic                 push, pop, tick, start_ok, load_timer, sout_d;

  assign push     = i_write && !fifo_full;
  assign o_ready  = !fifo_full;
  assign start_ok = i_enable && !fifo_empty;
  assign tick     = (timer_q == '0);

  // A bit lasts N cycles, so the down-counter starts at N-1; N=0 behaves as 1.
  function automatic logic [DIV_W-1:0] last_count(input logic [DIV_W-1:0] n);
    return (n == '0) ? '0 : n - DIV_W'(1);
  endfunction

  sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK    (CLK),
    .i_reset(i_reset),
    .push   (push),
    .pop    (pop),
    .wr_dat (i_dat),
    .rd_dat (fifo_dat),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (o_level)
  );

  always_ff @(posedge CLK or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      bit_q      <= '0;
      timer_q    <= '0;
      cpb_q      <= '0;
      par_q      <= PAR_NONE;
      two_q      <= 1'b0;
      par_bit_q  <= 1'b0;
      data_q     <= '0;
      o_sout     <= 1'b1;
      o_overflow <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      o_sout     <= sout_d;
      o_overflow <= i_write && fifo_full;
      if (pop) begin
        cpb_q     <= i_cycles_per_bit;
        par_q     <= i_parity_mode;
        two_q     <= i_two_stop;
        data_q    <= fifo_dat;
        par_bit_q <= (^fifo_dat) ^ (i_parity_mode == PAR_ODD);
        timer_q   <= last_count(i_cycles_per_bit);
      end else begin
        if (state_q == ST_DATA && tick) data_q <= data_q >> 1;
        if (load_timer)  timer_q <= last_count(cpb_q);
        else if (!tick)  timer_q <= timer_q - DIV_W'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    pop        = 1'b0;
    load_timer = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d = ST_START;
          pop     = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d    = ST_DATA;
          bit_d      = '0;
          load_timer = 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          load_timer = 1'b1;
          if (bit_q == BC_W'(DATA_BITS - 1)) begin
            state_d = parity_on(par_q) ? ST_PARITY : ST_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BC_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          bit_d      = '0;
          load_timer = 1'b1;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (two_q && bit_q == '0) begin
            bit_d      = BC_W'(1);
            load_timer = 1'b1;
          end else if (start_ok) begin
            state_d = ST_START;
            pop     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The line is registered, so it trails the state by one cycle.
  always_comb begin
    sout_d = 1'b1;
    o_busy = (state_q != ST_IDLE);
    case (state_q)
      ST_START:  sout_d = 1'b0;
      ST_DATA:   sout_d = data_q[0];
      ST_PARITY: sout_d = par_bit_q;
      default:   sout_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a 4-entry FIFO and 8 data bits.
module tb_uart_tx_fifo;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int DIV_W      = 16;

  logic        CLK = 1'b0;
  logic        i_reset;
  logic [15:0] i_cycles_per_bit;
  logic [1:0]  i_parity_mode;
  logic        i_two_stop;
  logic        i_enable;
  logic        i_write;
  logic [7:0]  i_dat;
  logic        o_ready;
  logic        o_overflow;
  logic [2:0]  o_level;
  logic        o_busy;
  logic        o_sout;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] burst [5] = '{8'h01, 8'h80, 8'hA5, 8'h3C, 8'hFF};

  // Frames are listed in line order from bit 0: start, data LSB first, [parity], stop(s).
  localparam logic [15:0] F_55      = {6'd0, 1'b1, 8'h55, 1'b0};
  localparam logic [15:0] F_55_EVEN = {5'd0, 1'b1, 1'b0, 8'h55, 1'b0};
  localparam logic [15:0] F_55_ODD2 = {4'd0, 2'b11, 1'b1, 8'h55, 1'b0};

  uart_tx_fifo #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH), .DIV_W(DIV_W)) dut (
    .CLK             (CLK),
    .i_reset         (i_reset),
    .i_cycles_per_bit(i_cycles_per_bit),
    .i_parity_mode   (i_parity_mode),
    .i_two_stop      (i_two_stop),
    .i_enable        (i_enable),
    .i_write         (i_write),
    .i_dat           (i_dat),
    .o_ready         (o_ready),
    .o_overflow      (o_overflow),
    .o_level         (o_level),
    .o_busy          (o_busy),
    .o_sout          (o_sout)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] np_frame(input logic [7:0] d);
    return {6'd0, 1'b1, d, 1'b0};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    i_write = 1'b1;
    i_dat   = d;
    step();
    i_write = 1'b0;
  endtask

  task automatic wait_start(input string tag, input int exp_lat);
    int cnt;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (o_sout !== 1'b0 && cnt < 64);
    check_eq(tag, cnt, exp_lat);
  endtask

  // Entered on the first start-bit sample; leaves on the sample after the frame.
  task automatic check_frame(input string tag, input logic [15:0] bits, input int nbits, input int n);
    logic [15:0] sh;
    int errs;
    sh   = bits;
    errs = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int k = 0; k < n; k++) begin
        if (o_sout !== sh[0]) errs++;
        step();
      end
      sh = sh >> 1;
    end
    check_eq({tag, "_bad_cycles"}, errs, 0);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_sout"}, o_sout, 1'b1);
    check_eq({tag, "_busy"}, o_busy, 1'b0);
    check_eq({tag, "_level"}, o_level, 3'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lows;
    i_reset          = 1'b1;
    i_write          = 1'b0;
    i_dat            = 8'h00;
    i_enable         = 1'b1;
    i_cycles_per_bit = 16'd4;
    i_parity_mode    = 2'b00;
    i_two_stop       = 1'b0;

    #2;
    check_eq("rst_sout", o_sout, 1'b1);
    check_eq("rst_busy", o_busy, 1'b0);
    check_eq("rst_level", o_level, 3'd0);
    check_eq("rst_ready", o_ready, 1'b1);
    check_eq("rst_ovf", o_overflow, 1'b0);
    step();
    step();
    i_reset = 1'b0;
    step();

    // 0x55, N=4, no parity, one stop
    write_word(8'h55);
    wait_start("lat_55", 2);
    check_frame("f55", F_55, 10, 4);
    check_idle("f55_end");

    // N=0 behaves as one cycle per bit
    i_cycles_per_bit = 16'd0;
    write_word(8'hA3);
    wait_start("lat_n0", 2);
    check_frame("fA3_n0", np_frame(8'hA3), 10, 1);
    check_idle("n0_end");

    // Even parity, then odd parity with two stop bits
    i_cycles_per_bit = 16'd4;
    i_parity_mode    = 2'b10;
    write_word(8'h55);
    wait_start("lat_even", 2);
    check_frame("f55_even", F_55_EVEN, 11, 4);
    check_idle("even_end");
    i_parity_mode = 2'b01;
    i_two_stop    = 1'b1;
    write_word(8'h55);
    wait_start("lat_odd2", 2);
    check_frame("f55_odd2", F_55_ODD2, 12, 4);
    check_idle("odd2_end");
    i_parity_mode = 2'b00;
    i_two_stop    = 1'b0;

    // Fill a disabled transmitter past capacity
    i_enable = 1'b0;
    i_write  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_dat = burst[k];
      step();
      check_eq($sformatf("ovf_w%0d", k), o_overflow, (k == 4));
    end
    i_write = 1'b0;
    check_eq("full_level", o_level, 3'd4);
    check_eq("full_ready", o_ready, 1'b0);
    check_eq("full_busy", o_busy, 1'b0);
    step();
    check_eq("ovf_clear", o_overflow, 1'b0);
    check_eq("full_hold", o_level, 3'd4);

    // Enable with N=2: four frames back to back, dropped 0xFF never sent
    i_cycles_per_bit = 16'd2;
    i_enable         = 1'b1;
    wait_start("lat_burst", 2);
    for (int f = 0; f < 4; f++) check_frame($sformatf("burst%0d", f), np_frame(burst[f]), 10, 2);
    check_idle("burst_end");
    check_eq("burst_ready", o_ready, 1'b1);

    // Simultaneous push/pop, then a mid-frame bit-period change
    i_cycles_per_bit = 16'd4;
    i_write = 1'b1;
    i_dat   = 8'h0F;
    step();
    i_dat = 8'hF0;
    step();
    i_write = 1'b0;
    check_eq("pushpop_level", o_level, 3'd1);
    check_eq("pushpop_busy", o_busy, 1'b1);
    wait_start("lat_pp", 1);
    i_cycles_per_bit = 16'd8;
    check_frame("f0F_n4", np_frame(8'h0F), 10, 4);
    check_frame("fF0_n8", np_frame(8'hF0), 10, 8);
    check_idle("nchg_end");

    // Reset during data bit 3 with a second word still queued
    i_cycles_per_bit = 16'd4;
    i_write = 1'b1;
    i_dat   = 8'h00;
    step();
    step();
    i_write = 1'b0;
    wait_start("lat_rst", 1);
    for (int c = 0; c < 17; c++) step();
    check_eq("pre_rst_low", o_sout, 1'b0);
    #2;
    i_reset = 1'b1;
    #1;
    check_eq("midrst_sout", o_sout, 1'b1);
    check_eq("midrst_busy", o_busy, 1'b0);
    check_eq("midrst_level", o_level, 3'd0);
    check_eq("midrst_ready", o_ready, 1'b1);
    step();
    i_reset = 1'b0;
    lows = 0;
    for (int c = 0; c < 60; c++) begin
      step();
      if (o_sout !== 1'b1 || o_busy !== 1'b0) lows++;
    end
    check_eq("post_rst_quiet", lows, 0);
    check_eq("post_rst_level", o_level, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, giving data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving transmit FIFO entries; legal values are powers of 2 from 2 to 256.
REQ-003 SHALL have parameter DIV_W, default 16, giving the width of the bit-period input.
REQ-004 SHALL have port CLK, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port i_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port i_cycles_per_bit, input, DIV_W bits: CLK cycles per serial bit.
REQ-007 SHALL have port i_parity_mode, input, 2 bits: 00 none, 01 odd, 10 even, 11 none (reserved).
REQ-008 SHALL have port i_two_stop, input, 1 bit: 1 selects two stop bits, 0 selects one.
REQ-009 SHALL have port i_enable, input, 1 bit: when 1, new frames may start.
REQ-010 SHALL have port i_write, input, 1 bit: write request.
REQ-011 SHALL have port i_dat, input, DATA_BITS bits: write data.
REQ-012 SHALL have port o_ready, output, 1 bit: FIFO not full.
REQ-013 SHALL have port o_overflow, output, 1 bit: one-cycle pulse when a write is dropped.
REQ-014 SHALL have port o_level, output, clog2(FIFO_DEPTH)+1 bits: FIFO occupancy.
REQ-015 SHALL have port o_busy, output, 1 bit: a frame is in progress.
REQ-016 SHALL have port o_sout, output, 1 bit: serial line, idle high.

Function
REQ-017 SHALL accept a write on a CLK edge where i_write=1 and o_ready=1.
REQ-018 SHALL drive o_ready as !(o_level==FIFO_DEPTH), combinationally from the registered count; a write while full SHALL be rejected even if a pop occurs in the same cycle.
REQ-019 SHALL, on a write with o_ready=0, leave the FIFO unchanged and assert o_overflow for exactly the next cycle.
REQ-020 SHALL use state machine IDLE -> START -> DATA -> PARITY (only if parity enabled) -> STOP -> IDLE or START.
REQ-021 SHALL, in IDLE with i_enable=1 and FIFO non-empty, pop one word and latch i_cycles_per_bit, i_parity_mode and i_two_stop; changes to these inputs mid-frame SHALL have no effect.
REQ-022 SHALL drive o_sout low on the 2nd rising edge after the write-accepting edge when the write goes into an empty FIFO while IDLE and enabled.
REQ-023 SHALL serialise the frame as: start bit 0, DATA_BITS data bits LSB first, optional parity bit, then 1 or 2 stop bits at 1.
REQ-024 SHALL make the parity bit equal to the XOR of the data bits for even parity, and its inverse for odd parity.
REQ-025 SHALL hold each bit for exactly N = i_cycles_per_bit CLK cycles, with N=0 treated as 1, using a down-counter of DIV_W bits.
REQ-026 SHALL, at the end of the last stop bit, go directly to START with no idle gap if i_enable=1 and the FIFO is non-empty, and otherwise to IDLE.
REQ-027 SHALL, when i_enable=0, finish any frame in progress and then not start a new one.
REQ-028 SHALL assert o_busy in every state except IDLE.
REQ-029 SHALL apply a simultaneous write and pop with the FIFO neither full nor empty so that o_level is unchanged and both operations take effect.
REQ-030 SHALL wrap the FIFO pointers modulo FIFO_DEPTH, with one extra bit used for the full/empty distinction.

Reset
REQ-031 SHALL, while i_reset=1, immediately force o_sout=1, o_busy=0, o_overflow=0, o_level=0, o_ready=1, state IDLE, and both counters to 0.
REQ-032 SHALL, when reset is asserted mid-frame, abort the frame at once, discard FIFO contents, and emit no truncated stop bit.
REQ-033 SHALL leave FIFO storage RAM unreset; only its pointers are reset.

Structure
REQ-034 SHALL place the parity-mode constants (PAR_NONE, PAR_ODD, PAR_EVEN) and the state encoding in shared package uart_pkg.
REQ-035 SHALL implement the FIFO as sub-module sync_fifo, parameterised by width and depth, with push, pop, full, empty and level.

Verification
REQ-036 SHALL cover: DATA_BITS=8, N=4, no parity, 1 stop, write 0x55 -> o_sout shows 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, 40 cycles total, then o_busy=0.
REQ-037 SHALL cover: same byte with even parity, then with odd parity -> parity bit 0, then 1; with i_two_stop=1 the frame is 12 bits (48 cycles).
REQ-038 SHALL cover: FIFO_DEPTH=4, i_enable=0, 5 consecutive writes -> the first 4 are accepted, o_level=4, o_ready=0, and one o_overflow pulse occurs on the 5th.
REQ-039 SHALL cover: then i_enable=1, N=2 -> 4 back-to-back frames with no high gap between stop and start, after which o_level=0 and o_ready=1.
REQ-040 SHALL cover: change i_cycles_per_bit from 4 to 8 mid-frame -> the current frame keeps 4-cycle bits and the next frame uses 8.
REQ-041 SHALL cover: assert i_reset during data bit 3 -> o_sout=1 within the same cycle, o_level=0, o_busy=0, and no further frame after release.
